single_port_ram_controller: RTL and testbench
=============================================

SINGLE_PORT_RAM_CONTROLLER -- requirements
Module: single_port_ram_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of RAM words.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default CLOG2(DEPTH): address width.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port write_request_valid, input, 1 bit, and write_request_ready, output, 1 bit: write channel handshake.
REQ-007 SHALL have port write_request_address, input, ADDRESS_WIDTH bits, and write_request_data, input, WIDTH bits: write payload.
REQ-008 SHALL have port read_request_valid, input, 1 bit, and read_request_ready, output, 1 bit: read channel handshake.
REQ-009 SHALL have port read_request_address, input, ADDRESS_WIDTH bits: read payload.
REQ-010 SHALL have port read_response_valid, output, 1 bit, and read_response_ready, input, 1 bit: response handshake.
REQ-011 SHALL have port read_response_data, output, WIDTH bits: returned word.
REQ-012 SHALL have ports ram_write_enable, ram_read_enable, ram_address and ram_write_data as outputs (1, 1, ADDRESS_WIDTH, WIDTH bits): the RAM port.
REQ-013 SHALL have port ram_read_data, input, WIDTH bits: combinational RAM read data, valid in the same cycle as ram_read_enable.

Function
REQ-014 A transfer SHALL occur on a channel in a cycle where valid and ready are both high at the rising edge.
REQ-015 At most one of write_request_ready and read_request_ready SHALL be high in any cycle.
REQ-016 A read SHALL be eligible only when the response register is empty or read_response_ready is high in the same cycle.
REQ-017 Grant when only one eligible request is pending: that request; when none is pending: no grant, both ram enables low.
REQ-018 Grant when both are pending and eligible: decided by the arbitration policy (REQ-029/030).
REQ-019 A granted write SHALL drive ram_write_enable=1, ram_address=write_request_address and ram_write_data=write_request_data combinationally in the same cycle, and complete at that edge.
REQ-020 A granted read SHALL drive ram_read_enable=1 and ram_address=read_request_address; ram_read_data SHALL be captured into the response register at that edge.
REQ-021 Read latency SHALL be exactly 1: accepted at edge N means read_response_valid=1 after edge N.
REQ-022 read_response_valid and read_response_data SHALL hold stable until the response handshake; an accept and a drain at the same edge SHALL leave valid=1 with the new data.
REQ-023 Drain without a new accept SHALL clear read_response_valid at that edge.
REQ-024 Read after write to the same address in consecutive cycles SHALL return the newly written data.
REQ-025 ram_write_data SHALL be 0 when no write is granted; ram_address SHALL be 0 when there is no grant.

Reset
REQ-026 Asserting resetn low SHALL asynchronously clear read_response_valid and read_response_data to 0, and reset the round-robin state to favour read.
REQ-027 While resetn is low, both ready outputs and both ram enables SHALL be 0.
REQ-028 Reset mid-read SHALL discard the pending response; nothing SHALL be returned after reset release.

Configuration
REQ-029 With macro SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN defined: contention SHALL alternate; the side not granted last time wins, and a one-bit last-grant register updates only on a granted transfer.
REQ-030 Without SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN: contention SHALL always grant write (fixed priority); no last-grant register SHALL exist.

Structure
REQ-031 Grant encoding constants (GRANT_NONE, GRANT_WRITE, GRANT_READ) SHALL live in the shared memory constants header/package.
REQ-032 Arbitration SHALL be a sub-module, round_robin_arbiter_2, instantiated only when the macro is defined; the RAM itself SHALL stay outside this block.

Verification
REQ-033 Reset, then write 0xA5 to address 3, then read address 3 -> read_response_valid after 1 cycle, data 0xA5.
REQ-034 Both requests held valid for 4 cycles with macro defined -> grants R,W,R,W; without the macro -> W,W,W,W.
REQ-035 Response pending with read_response_ready=0 and a read requested -> read_request_ready=0, a write to address 5 still accepted.
REQ-036 Response pending, ready=1, new read of address 3 in the same cycle -> valid stays 1, data switches at that edge, no bubble.
REQ-037 resetn pulsed low one cycle after a read of address 7 is accepted -> read_response_valid=0 immediately, no response after release.
REQ-038 Write 0x3C to address 15 then read address 15 in the next cycle -> response 0x3C.

Source files
------------

// File: rtl/single_port_ram_controller_pkg.sv
// Shared constants for the single-port RAM controller: grant encoding and the
// fixed-priority grant function used when round-robin arbitration is not built.
package single_port_ram_controller_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_WRITE = 2'd1,
        GRANT_READ  = 2'd2
    } grant_t;

    // Write always wins contention.
    function automatic grant_t fixed_priority_grant(input logic write_pending,
                                                    input logic read_pending);
        grant_t grant;
        grant = GRANT_NONE;
        if (write_pending)
            grant = GRANT_WRITE;
        else if (read_pending)
            grant = GRANT_READ;
        return grant;
    endfunction

endpackage

// File: rtl/single_port_ram_controller_if.sv
// Bus bundle for the RAM controller: write/read request channels, read response
// channel and the RAM port. slave is the controller's view, master the client+RAM view.
interface single_port_ram_controller_if #(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     write_request_valid;
    logic                     write_request_ready;
    logic [ADDRESS_WIDTH-1:0] write_request_address;
    logic [WIDTH-1:0]         write_request_data;

    logic                     read_request_valid;
    logic                     read_request_ready;
    logic [ADDRESS_WIDTH-1:0] read_request_address;

    logic                     read_response_valid;
    logic                     read_response_ready;
    logic [WIDTH-1:0]         read_response_data;

    logic                     ram_write_enable;
    logic                     ram_read_enable;
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic [WIDTH-1:0]         ram_write_data;
    logic [WIDTH-1:0]         ram_read_data;

    modport slave (
        input  write_request_valid, write_request_address, write_request_data,
        input  read_request_valid, read_request_address, read_response_ready,
        input  ram_read_data,
        output write_request_ready, read_request_ready,
        output read_response_valid, read_response_data,
        output ram_write_enable, ram_read_enable, ram_address, ram_write_data
    );

    modport master (
        output write_request_valid, write_request_address, write_request_data,
        output read_request_valid, read_request_address, read_response_ready,
        output ram_read_data,
        input  write_request_ready, read_request_ready,
        input  read_response_valid, read_response_data,
        input  ram_write_enable, ram_read_enable, ram_address, ram_write_data
    );

endinterface

// File: rtl/single_port_ram_controller_arbiter.sv
// round_robin_arbiter_2: two-way write/read arbiter that alternates on contention.
// Used by single_port_ram_controller only when SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN is defined.
module round_robin_arbiter_2
    import single_port_ram_controller_pkg::*;
(
    input  logic   clock,
    input  logic   resetn,
    input  logic   write_pending,
    input  logic   read_pending,
    output grant_t grant
);

    // Reset value 1 means "write went last", so read wins the first contention.
    logic last_grant_write;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            last_grant_write <= 1'b1;
        else if (grant != GRANT_NONE)
            last_grant_write <= (grant == GRANT_WRITE);
    end

    always_comb begin
        grant = GRANT_NONE;
        if (write_pending && read_pending)
            grant = last_grant_write ? GRANT_READ : GRANT_WRITE;
        else if (write_pending)
            grant = GRANT_WRITE;
        else if (read_pending)
            grant = GRANT_READ;
    end

endmodule

// File: rtl/single_port_ram_controller.sv
// Single-port RAM controller: arbitrates write/read requests onto one RAM port
// with a one-deep read response register. Round-robin contention when
// SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN is defined, otherwise write priority.
module single_port_ram_controller
    import single_port_ram_controller_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
)(
    input  logic                        clock,
    input  logic                        resetn,
    single_port_ram_controller_if.slave bus
);

    logic                     response_valid;
    logic [WIDTH-1:0]         response_data;
    logic                     read_eligible;
    logic                     write_pending;
    logic                     read_pending;
    logic [ADDRESS_WIDTH-1:0] address_next;
    grant_t                   grant;

    // A read may only be accepted if its result has somewhere to land this edge.
    assign read_eligible = !response_valid || bus.read_response_ready;
    assign write_pending = resetn && bus.write_request_valid;
    assign read_pending  = resetn && bus.read_request_valid && read_eligible;

`ifdef SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN
    round_robin_arbiter_2 u_arbiter (
        .clock         (clock),
        .resetn        (resetn),
        .write_pending (write_pending),
        .read_pending  (read_pending),
        .grant         (grant)
    );
`else
    assign grant = fixed_priority_grant(write_pending, read_pending);
`endif

    always_comb begin
        bus.write_request_ready = 1'b0;
        bus.read_request_ready  = 1'b0;
        bus.ram_write_enable    = 1'b0;
        bus.ram_read_enable     = 1'b0;
        bus.ram_write_data      = '0;
        address_next            = '0;
        case (grant)
            GRANT_WRITE: begin
                bus.write_request_ready = 1'b1;
                bus.ram_write_enable    = 1'b1;
                bus.ram_write_data      = bus.write_request_data;
                address_next            = bus.write_request_address;
            end
            GRANT_READ: begin
                bus.read_request_ready = 1'b1;
                bus.ram_read_enable    = 1'b1;
                address_next           = bus.read_request_address;
            end
            default: ;
        endcase
        bus.ram_address = address_next;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            response_valid <= 1'b0;
            response_data  <= '0;
        end else if (grant == GRANT_READ) begin
            response_valid <= 1'b1;
            response_data  <= bus.ram_read_data;
        end else if (response_valid && bus.read_response_ready) begin
            response_valid <= 1'b0;
        end
    end

    assign bus.read_response_valid = response_valid;
    assign bus.read_response_data  = response_data;

endmodule

// File: tb/tb_single_port_ram_controller.sv
// Directed testbench for single_port_ram_controller with a behavioural RAM model.
module tb_single_port_ram_controller;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    single_port_ram_controller_if #(.WIDTH(WIDTH), .ADDRESS_WIDTH(AW)) bus ();

    single_port_ram_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clock)
        if (bus.ram_write_enable)
            mem[bus.ram_address] <= bus.ram_write_data;
    assign bus.ram_read_data = mem[bus.ram_address];

    task automatic idle_inputs();
        bus.write_request_valid   = 1'b0;
        bus.write_request_address = '0;
        bus.write_request_data    = '0;
        bus.read_request_valid    = 1'b0;
        bus.read_request_address  = '0;
        bus.read_response_ready   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.write_request_valid  = 1'b1;
        bus.read_request_valid   = 1'b1;
        bus.read_response_ready  = 1'b1;
        #2;
        tests_run++;
        if ({bus.write_request_ready, bus.read_request_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_readies: got %b expected 00", {bus.write_request_ready, bus.read_request_ready});
        end
        tests_run++;
        if ({bus.ram_write_enable, bus.ram_read_enable} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_enables: got %b expected 00", {bus.ram_write_enable, bus.ram_read_enable});
        end
        tests_run++;
        if (bus.read_response_valid !== 1'b0 || bus.read_response_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_response: got valid %b data %h expected 0/00", bus.read_response_valid, bus.read_response_data);
        end
        @(negedge clock);
        idle_inputs();
        resetn = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clock);
        bus.write_request_valid   = 1'b1;
        bus.write_request_address = 4'd3;
        bus.write_request_data    = 8'hA5;
        #1;
        tests_run++;
        if ({bus.write_request_ready, bus.ram_write_enable, bus.ram_address, bus.ram_write_data} !== {1'b1, 1'b1, 4'd3, 8'hA5}) begin
            tests_failed++;
            $display("FAIL write_grant: got rdy %b we %b addr %0d wdata %h expected 1 1 3 a5",
                     bus.write_request_ready, bus.ram_write_enable, bus.ram_address, bus.ram_write_data);
        end
        @(posedge clock);
        @(negedge clock);
        bus.write_request_valid  = 1'b0;
        bus.read_request_valid   = 1'b1;
        bus.read_request_address = 4'd3;
        #1;
        tests_run++;
        if ({bus.read_request_ready, bus.ram_read_enable, bus.ram_address, bus.ram_write_data, bus.read_response_valid}
            !== {1'b1, 1'b1, 4'd3, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL read_grant: got rdy %b re %b addr %0d wdata %h rvalid %b expected 1 1 3 00 0",
                     bus.read_request_ready, bus.ram_read_enable, bus.ram_address, bus.ram_write_data, bus.read_response_valid);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b1 || bus.read_response_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL read_latency: got valid %b data %h expected 1/a5", bus.read_response_valid, bus.read_response_data);
        end
        @(negedge clock);
        bus.read_request_valid  = 1'b0;
        bus.read_response_ready = 1'b1;
        #1;
        tests_run++;
        if ({bus.ram_write_enable, bus.ram_read_enable, bus.ram_address, bus.ram_write_data, bus.write_request_ready}
            !== {1'b0, 1'b0, 4'd0, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL idle_port: got we %b re %b addr %0d wdata %h wrdy %b expected 0 0 0 00 0",
                     bus.ram_write_enable, bus.ram_read_enable, bus.ram_address, bus.ram_write_data, bus.write_request_ready);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_clears: got valid %b expected 0", bus.read_response_valid);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_read;
`ifdef SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN
        exp_read = 4'b0101;
`else
        exp_read = 4'b0000;
`endif
        pulse_reset();
        bus.write_request_valid   = 1'b1;
        bus.write_request_address = 4'd1;
        bus.write_request_data    = 8'h10;
        bus.read_request_valid    = 1'b1;
        bus.read_request_address  = 4'd2;
        bus.read_response_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (bus.read_request_ready !== exp_read[i] || bus.write_request_ready !== !exp_read[i]) begin
                tests_failed++;
                $display("FAIL arb_cycle%0d: got wrdy %b rrdy %b expected wrdy %b rrdy %b",
                         i, bus.write_request_ready, bus.read_request_ready, !exp_read[i], exp_read[i]);
            end
            @(posedge clock);
            @(negedge clock);
            bus.write_request_data = bus.write_request_data + 8'h01;
        end
        bus.write_request_valid = 1'b0;
        bus.read_request_valid  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_backpressure();
        bus.read_request_valid   = 1'b1;
        bus.read_request_address = 4'd3;
        @(posedge clock);
        @(negedge clock);
        bus.read_request_address  = 4'd7;
        bus.write_request_valid   = 1'b1;
        bus.write_request_address = 4'd5;
        bus.write_request_data    = 8'h5A;
        #1;
        tests_run++;
        if ({bus.read_request_ready, bus.write_request_ready, bus.ram_write_enable, bus.ram_address} !== {1'b0, 1'b1, 1'b1, 4'd5}) begin
            tests_failed++;
            $display("FAIL backpressure_grant: got rrdy %b wrdy %b we %b addr %0d expected 0 1 1 5",
                     bus.read_request_ready, bus.write_request_ready, bus.ram_write_enable, bus.ram_address);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b1 || bus.read_response_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL response_hold: got valid %b data %h expected 1/a5", bus.read_response_valid, bus.read_response_data);
        end
        @(negedge clock);
        bus.write_request_valid  = 1'b0;
        bus.read_request_address = 4'd5;
        bus.read_response_ready  = 1'b1;
        #1;
        tests_run++;
        if (bus.read_request_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_eligible_on_drain: got rrdy %b expected 1", bus.read_request_ready);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b1 || bus.read_response_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL write_while_blocked: got valid %b data %h expected 1/5a", bus.read_response_valid, bus.read_response_data);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_drain_accept();
        bus.read_request_valid   = 1'b1;
        bus.read_request_address = 4'd3;
        bus.read_response_ready  = 1'b1;
        #1;
        tests_run++;
        if (bus.read_request_ready !== 1'b1 || bus.read_response_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL drain_accept_pre: got rrdy %b data %h expected 1/5a", bus.read_request_ready, bus.read_response_data);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b1 || bus.read_response_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL drain_accept_no_bubble: got valid %b data %h expected 1/a5", bus.read_response_valid, bus.read_response_data);
        end
        @(negedge clock);
        bus.read_request_valid = 1'b0;
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_after_accept: got valid %b expected 0", bus.read_response_valid);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        bus.write_request_valid   = 1'b1;
        bus.write_request_address = 4'd7;
        bus.write_request_data    = 8'h77;
        @(posedge clock);
        @(negedge clock);
        bus.write_request_valid  = 1'b0;
        bus.read_request_valid   = 1'b1;
        bus.read_request_address = 4'd7;
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b1 || bus.read_response_data !== 8'h77) begin
            tests_failed++;
            $display("FAIL mid_read_accept: got valid %b data %h expected 1/77", bus.read_response_valid, bus.read_response_data);
        end
        @(negedge clock);
        resetn                  = 1'b0;
        bus.write_request_valid = 1'b1;
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b0 || bus.read_response_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset_clear: got valid %b data %h expected 0/00", bus.read_response_valid, bus.read_response_data);
        end
        tests_run++;
        if ({bus.write_request_ready, bus.read_request_ready, bus.ram_write_enable, bus.ram_read_enable} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_gates_port: got %b expected 0000",
                     {bus.write_request_ready, bus.read_request_ready, bus.ram_write_enable, bus.ram_read_enable});
        end
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        idle_inputs();
        bus.read_response_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            tests_run++;
            if (bus.read_response_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL no_response_after_reset%0d: got valid %b expected 0", i, bus.read_response_valid);
            end
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_raw_boundary();
        bus.write_request_valid   = 1'b1;
        bus.write_request_address = 4'd15;
        bus.write_request_data    = 8'h3C;
        #1;
        tests_run++;
        if (bus.ram_address !== 4'd15 || bus.ram_write_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL top_address_write: got addr %0d wdata %h expected 15/3c", bus.ram_address, bus.ram_write_data);
        end
        @(posedge clock);
        @(negedge clock);
        bus.write_request_valid  = 1'b0;
        bus.read_request_valid   = 1'b1;
        bus.read_request_address = 4'd15;
        @(posedge clock);
        #1;
        tests_run++;
        if (bus.read_response_valid !== 1'b1 || bus.read_response_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL read_after_write: got valid %b data %h expected 1/3c", bus.read_response_valid, bus.read_response_data);
        end
        @(negedge clock);
        idle_inputs();
        bus.read_response_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_backpressure();
        test_drain_accept();
        test_reset_mid_read();
        test_raw_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
